branch_pc_unit: RTL and testbench

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

---
 rtl/branch_pc_unit_pkg.sv | 8 +
 rtl/branch_pc_unit_if.sv | 27 ++
 rtl/sat_counter16.sv | 12 +
 rtl/branch_pc_unit.sv | 62 ++++++
 tb/tb_branch_pc_unit.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/branch_pc_unit_pkg.sv
// branch_pc_unit_pkg: shared pipeline defaults, FSM state encoding and counter widths
package branch_pc_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int REFILL_DEPTH_DEF = 3;
  localparam int CNT_W = 16;
  localparam int RCNT_W = 8;
  typedef enum logic {RUN, REFILL} state_t;
endpackage

// File: rtl/branch_pc_unit_if.sv
// branch_pc_unit_if: hazard/EX-MEM control inputs and pc/perf outputs; master drives inputs, slave is the unit
interface branch_pc_unit_if;
  import branch_pc_unit_pkg::*;
  logic stall;
  logic mem_valid;
  logic mem_beq;
  logic mem_bne;
  logic mem_jump;
  logic mem_zero;
  logic [31:0] mem_branch_target;
  logic [31:0] mem_jump_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic PCSrc;
  logic refill;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic misalign;
  modport master (
    output stall, mem_valid, mem_beq, mem_bne, mem_jump, mem_zero, mem_branch_target, mem_jump_target,
    input pc, pc_plus4, PCSrc, refill, branch_cnt, taken_cnt, misalign
  );
  modport slave (
    input stall, mem_valid, mem_beq, mem_bne, mem_jump, mem_zero, mem_branch_target, mem_jump_target,
    output pc, pc_plus4, PCSrc, refill, branch_cnt, taken_cnt, misalign
  );
endinterface

// File: rtl/sat_counter16.sv
// sat_counter16: enable-driven saturating counter (clk, rst, en -> q)
module sat_counter16
  import branch_pc_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : (en && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: pc register with MEM-stage redirect, refill FSM, perf counters and misalign flag (clk, rst, bus)
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int REFILL_DEPTH = REFILL_DEPTH_DEF
) (
  input logic clk,
  input logic rst,
  branch_pc_unit_if.slave b
);
  logic [31:0] pc_q, pc4, tgt;
  logic take, mis;
  state_t state, state_n;
  logic [RCNT_W-1:0] cnt, cnt_n;
  always_comb begin
    take = b.mem_valid & ((b.mem_beq & b.mem_zero) | (b.mem_bne & ~b.mem_zero) | b.mem_jump);
    tgt = b.mem_jump ? b.mem_jump_target : b.mem_branch_target;
    pc4 = pc_q + 32'd4;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (take) begin
      state_n = REFILL;
      cnt_n = RCNT_W'(REFILL_DEPTH - 1);
    end else if (state == REFILL && !b.stall) begin
      state_n = (cnt == '0) ? RUN : REFILL;
      cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      pc_q <= RESET_PC;
      mis <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pc_q <= take ? {tgt[31:2], 2'b00} : b.stall ? pc_q : pc4;
      mis <= mis | (take & |tgt[1:0]);
    end
  end
  assign b.pc = pc_q;
  assign b.pc_plus4 = pc4;
  assign b.PCSrc = take;
  assign b.refill = (state == REFILL);
  assign b.misalign = mis;
  sat_counter16 u_branch_cnt (
    .clk(clk),
    .rst(rst),
    .en(b.mem_valid & (b.mem_beq | b.mem_bne)),
    .q(b.branch_cnt)
  );
  sat_counter16 u_taken_cnt (
    .clk(clk),
    .rst(rst),
    .en(take),
    .q(b.taken_cnt)
  );
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed stimulus with a cycle model and literal checkpoints
module tb_branch_pc_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int DEPTH = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  branch_pc_unit_if bus();
  branch_pc_unit #(.RESET_PC(RPC), .REFILL_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  logic [31:0] m_pc;
  int m_rem, m_bc, m_tc;
  logic m_mis;
  function automatic logic m_take();
    return bus.mem_valid && ((bus.mem_beq && bus.mem_zero) || (bus.mem_bne && !bus.mem_zero) || bus.mem_jump);
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    logic [31:0] t;
    if (rst) begin
      m_pc = RPC; m_rem = 0; m_bc = 0; m_tc = 0; m_mis = 1'b0;
    end else begin
      t = bus.mem_jump ? bus.mem_jump_target : bus.mem_branch_target;
      if (bus.mem_valid && (bus.mem_beq || bus.mem_bne) && m_bc < 65535) m_bc++;
      if (m_take()) begin
        if (m_tc < 65535) m_tc++;
        m_pc = t & 32'hFFFF_FFFC;
        m_rem = DEPTH;
        if (t % 4 != 0) m_mis = 1'b1;
      end else if (!bus.stall) begin
        m_pc = m_pc + 32'd4;
        if (m_rem > 0) m_rem--;
      end
    end
  end
  always @(negedge clk) if (chk) begin
    check("pc", bus.pc, m_pc);
    check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    check("PCSrc", 32'(bus.PCSrc), 32'(m_take()));
    check("refill", 32'(bus.refill), 32'(m_rem > 0));
    check("branch_cnt", 32'(bus.branch_cnt), 32'(m_bc));
    check("taken_cnt", 32'(bus.taken_cnt), 32'(m_tc));
    check("misalign", 32'(bus.misalign), 32'(m_mis));
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, beq, bne, jmp, z, input logic [31:0] bt, jt, input logic st);
    bus.mem_valid = v; bus.mem_beq = beq; bus.mem_bne = bne; bus.mem_jump = jmp; bus.mem_zero = z;
    bus.mem_branch_target = bt; bus.mem_jump_target = jt; bus.stall = st;
    #1;
  endtask
  initial begin
    logic [31:0] p;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(2);
    chk = 1'b1;
    rst = 1'b0;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_refill", 32'(bus.refill), 0);
    check("rst_taken", 32'(bus.taken_cnt), 0);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("seq_pc", bus.pc, 32'(4 * i));
    end
    drive(1, 1, 0, 0, 1, 32'h40, 0, 0);
    check("beq_pcsrc", 32'(bus.PCSrc), 1);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("beq_pc", bus.pc, 32'h40);
    check("beq_bc", 32'(bus.branch_cnt), 1);
    check("beq_tc", 32'(bus.taken_cnt), 1);
    check("beq_refill1", 32'(bus.refill), 1);
    step(2);
    check("beq_refill3", 32'(bus.refill), 1);
    step(1);
    check("beq_refill_end", 32'(bus.refill), 0);
    check("beq_pc_end", bus.pc, 32'h4C);
    drive(1, 0, 0, 1, 0, 0, 32'h100, 1);
    step(1);
    check("jmp_stall_pc", bus.pc, 32'h100);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step(2);
    check("stall_refill_pc", bus.pc, 32'h100);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(2);
    check("ext_refill", 32'(bus.refill), 1);
    step(1);
    check("ext_refill_end", 32'(bus.refill), 0);
    p = bus.pc;
    drive(1, 0, 1, 0, 1, 32'h200, 0, 0);
    check("bne_pcsrc", 32'(bus.PCSrc), 0);
    step(1);
    check("bne_pc", bus.pc, p + 32'd4);
    check("bne_bc", 32'(bus.branch_cnt), 2);
    check("bne_tc", 32'(bus.taken_cnt), 2);
    p = bus.pc;
    drive(0, 0, 0, 1, 0, 0, 32'h300, 0);
    check("inv_pcsrc", 32'(bus.PCSrc), 0);
    step(1);
    check("inv_pc", bus.pc, p + 32'd4);
    check("inv_tc", 32'(bus.taken_cnt), 2);
    drive(1, 1, 0, 0, 1, 32'h42, 0, 0);
    step(1);
    check("mis_pc", bus.pc, 32'h40);
    check("mis_flag", 32'(bus.misalign), 1);
    drive(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    check("wrap_p4", bus.pc_plus4, 32'h0);
    step(1);
    check("wrap_pc", bus.pc, 32'h0);
    check("mis_held", 32'(bus.misalign), 1);
    drive(1, 0, 0, 1, 0, 0, 32'h500, 0);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    check("mid_refill", 32'(bus.refill), 1);
    rst = 1'b1;
    drive(1, 0, 0, 1, 0, 0, 32'h700, 1);
    check("rst_pcsrc", 32'(bus.PCSrc), 1);
    step(1);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rstm_pc", bus.pc, RPC);
    check("rstm_refill", 32'(bus.refill), 0);
    check("rstm_mis", 32'(bus.misalign), 0);
    check("rstm_tc", 32'(bus.taken_cnt), 0);
    drive(1, 0, 0, 1, 0, 0, 32'h600, 0);
    step(65536);
    check("sat_tc", 32'(bus.taken_cnt), 32'hFFFF);
    step(2);
    check("sat_hold", 32'(bus.taken_cnt), 32'hFFFF);
    check("sat_bc", 32'(bus.branch_cnt), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    check("final_pc", bus.pc, 32'h604);
    @(negedge clk);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
